// File: rtl/clarvi_part_sequencer_if.sv
// rtl/clarvi_part_sequencer_if.sv - operand/ALU/writeback signal bundle for the part sequencer
interface clarvi_part_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_order;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        hold;
  logic        flush;
  logic [1:0]  alu_part;
  logic [15:0] alu_rs1;
  logic [15:0] alu_rs2;
  logic        alu_stall;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [63:0] wb_value;
  logic        wb_ready;

  modport master (
    output in_valid, in_order, in_rs1, in_rs2, hold, flush, alu_result, wb_ready,
    input  in_ready, alu_part, alu_rs1, alu_rs2, alu_stall, wb_valid, wb_value
  );

  modport slave (
    input  in_valid, in_order, in_rs1, in_rs2, hold, flush, alu_result, wb_ready,
    output in_ready, alu_part, alu_rs1, alu_rs2, alu_stall, wb_valid, wb_value
  );
endinterface

// File: rtl/clarvi_part_sequencer.sv
// rtl/clarvi_part_sequencer.sv - sequences a 64-bit operation as four 16-bit ALU parts
module clarvi_part_sequencer (
  input logic                    clock,
  input logic                    reset,
  clarvi_part_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  order_q;
  logic [63:0] rs1_q, rs2_q, result_q;
  logic [1:0]  part;
  logic        accept, capture;

  // Order 11 walks the low word high-half first, then the high word the same way.
  always_comb begin
    part = step_q;
    case (order_q)
      2'b01:   part = 2'd3 - step_q;
      2'b11:   part = {step_q[1], ~step_q[0]};
      default: part = step_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      order_q  <= 2'd0;
      rs1_q    <= 64'd0;
      rs2_q    <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        order_q <= bus.in_order;
        rs1_q   <= bus.in_rs1;
        rs2_q   <= bus.in_rs2;
      end
      if (capture) begin
        result_q[{part, 4'h0} +: 16] <= bus.alu_result;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    accept        = 1'b0;
    capture       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.alu_part  = 2'd0;
    bus.alu_stall = 1'b1;
    bus.wb_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = reset && !bus.flush;
        if (bus.in_valid && !bus.flush) begin
          accept  = 1'b1;
          state_d = ISSUE;
          step_d  = 2'd0;
        end
      end
      ISSUE: begin
        bus.alu_part = part;
        if (bus.flush) begin
          state_d = IDLE;
          step_d  = 2'd0;
        end else if (!bus.hold) begin
          bus.alu_stall = 1'b0;
          capture       = 1'b1;
          step_d        = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        bus.wb_valid = 1'b1;
        if (bus.flush || bus.wb_ready) begin
          state_d = IDLE;
          step_d  = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  assign bus.alu_rs1  = rs1_q[{bus.alu_part, 4'h0} +: 16];
  assign bus.alu_rs2  = rs2_q[{bus.alu_part, 4'h0} +: 16];
  assign bus.wb_value = result_q;

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
// tb/tb_clarvi_part_sequencer.sv - directed self-checking bench for clarvi_part_sequencer
module tb_clarvi_part_sequencer;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  logic        pass_mode;
  logic [15:0] model_val [4];

  clarvi_part_sequencer_if bus ();

  clarvi_part_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU stand-in: either xor of the presented slices or a per-part table.
  assign bus.alu_result = pass_mode ? (bus.alu_rs1 ^ bus.alu_rs2) : model_val[bus.alu_part];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] order, input logic [63:0] rs1,
                        input logic [63:0] rs2, input int hs, input int hl, input int bp,
                        input logic [63:0] exp_val, input logic [7:0] exp_seq, input int exp_cyc);
    int         cyc;
    int         nlow;
    int         bad;
    logic       got;
    logic [7:0] seq;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_order = order;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    #1;
    check({name, "_ready"}, bus.in_ready, 1);
    cyc  = 0;
    nlow = 0;
    got  = 1'b0;
    seq  = 8'd0;
    while (!got && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        bus.in_valid = 1'b0;
        bus.in_rs1   = ~rs1;
        bus.in_rs2   = ~rs2;
      end
      bus.hold = (cyc >= hs) && (cyc < hs + hl);
      #1;
      if (!bus.alu_stall) begin
        seq = {seq[5:0], bus.alu_part};
        nlow++;
      end
      if (bus.wb_valid) got = 1'b1;
    end
    bus.hold = 1'b0;
    check({name, "_wb_seen"}, got, 1);
    check({name, "_wb_cycle"}, cyc, exp_cyc);
    check({name, "_part_seq"}, seq, exp_seq);
    check({name, "_issue_cnt"}, nlow, 4);
    check({name, "_wb_value"}, bus.wb_value, exp_val);
    if (bp > 0) begin
      bad = 0;
      repeat (bp) begin
        @(negedge clock);
        #1;
        if (!bus.wb_valid || bus.wb_value !== exp_val || bus.in_ready) bad++;
      end
      check({name, "_bp_stable"}, bad, 0);
    end
    bus.wb_ready = 1'b1;
    @(negedge clock);
    bus.wb_ready = 1'b0;
    #1;
    check({name, "_post_wb_valid"}, bus.wb_valid, 0);
    check({name, "_post_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    pass_mode    = 1'b1;
    model_val[0] = 16'h0;
    model_val[1] = 16'h0;
    model_val[2] = 16'h0;
    model_val[3] = 16'h0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_order = 2'b00;
    bus.in_rs1   = 64'd0;
    bus.in_rs2   = 64'd0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_ready = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_stall", bus.alu_stall, 1);
    check("rst_part", bus.alu_part, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_value", bus.wb_value, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_release_ready", bus.in_ready, 1);

    run_op("asc", 2'b00, 64'h0004_0003_0002_0001, 64'd0, -1, 0, 0,
           64'h0004_0003_0002_0001, 8'h1B, 5);

    pass_mode    = 1'b0;
    model_val[0] = 16'h0001;
    model_val[1] = 16'h0000;
    model_val[2] = 16'h0000;
    model_val[3] = 16'h0000;
    run_op("desc", 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h1, -1, 0, 0,
           64'h0000_0000_0000_0001, 8'hE4, 5);

    model_val[0] = 16'hBBBB;
    model_val[1] = 16'hAAAA;
    model_val[2] = 16'hFFFF;
    model_val[3] = 16'hFFFF;
    run_op("shr32", 2'b11, 64'h0000_0000_8000_0000, 64'd4, -1, 0, 4,
           64'hFFFF_FFFF_AAAA_BBBB, 8'h4E, 5);

    pass_mode = 1'b1;
    run_op("op32", 2'b10, 64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, -1, 0, 0,
           64'h1E1E_2D2D_3C3C_4B4B, 8'h1B, 5);

    run_op("hold", 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 3, 3, 0,
           64'hDEAD_BEEF_CAFE_F00D, 8'h1B, 8);

    // flush at step 1
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_order = 2'b00;
    bus.in_rs1   = 64'h5555_6666_7777_8888;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    bus.flush = 1'b1;
    #1;
    check("flush_part_step1", bus.alu_part, 1);
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    check("flush_idle_ready", bus.in_ready, 1);
    check("flush_wb_valid", bus.wb_valid, 0);
    check("flush_stall", bus.alu_stall, 1);

    // flush in IDLE blocks acceptance
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    #1;
    check("flush_idle_block", bus.in_ready, 0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("flush_idle_not_taken", bus.in_ready, 1);

    // asynchronous reset at step 2
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_order = 2'b00;
    bus.in_rs1   = 64'h9999_AAAA_BBBB_CCCC;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("mid_part_step2", bus.alu_part, 2);
    #1;
    reset = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_stall", bus.alu_stall, 1);
    check("arst_part", bus.alu_part, 0);
    check("arst_wb_valid", bus.wb_valid, 0);
    check("arst_wb_value", bus.wb_value, 0);
    check("arst_rs1_slice", bus.alu_rs1, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("arst_release_ready", bus.in_ready, 1);

    run_op("asc2", 2'b00, 64'h0004_0003_0002_0001, 64'd0, -1, 0, 0,
           64'h0004_0003_0002_0001, 8'h1B, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clarvi_part_sequencer.md
CLARVI_PART_SEQUENCER -- requirements
Module: clarvi_part_sequencer

Interface
- REQ-001 The block SHALL have no parameters; the slice width is fixed at 16 bits and the operand width at 64 bits.
- REQ-002 clock  input  1  rising-edge clock for all state.
- REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-004 in_valid  input  1  an operation is offered.
- REQ-005 in_ready  output  1  the sequencer accepts the offered operation this cycle.
- REQ-006 in_order  input  2  part order: 00 = ascending 0,1,2,3; 01 = descending 3,2,1,0 (SLT/SLTU, 64-bit SRL/SRA); 10 = 32-bit op 0,1,2,3; 11 = 32-bit right shift 1,0,3,2.
- REQ-007 in_rs1, in_rs2  input  64 each  full operands.
- REQ-008 hold  input  1  pipeline hold; freezes sequencing.
- REQ-009 flush  input  1  abort any operation in progress.
- REQ-010 alu_part  output  2  instr_part presented to the 16-bit ALU.
- REQ-011 alu_rs1, alu_rs2  output  16 each  operand slices [16*alu_part+15 : 16*alu_part].
- REQ-012 alu_stall  output  1  stall to the ALU; 0 only on cycles that issue a part.
- REQ-013 alu_result  input  16  ALU combinational result for the current part.
- REQ-014 wb_valid  output  1  the assembled 64-bit result is available.
- REQ-015 wb_value  output  64  the assembled result.
- REQ-016 wb_ready  input  1  the consumer takes wb_value.

Function
- REQ-017 The FSM SHALL have states IDLE, ISSUE and DONE, plus a 2-bit step counter (0..3).
- REQ-018 in_ready SHALL be 1 only in IDLE with flush=0; an operation is accepted on a rising edge with in_valid && in_ready, and the block registers in_rs1, in_rs2 and in_order and moves to ISSUE with step=0.
- REQ-019 In ISSUE, alu_part SHALL equal the order-table entry for the current step, from the registered in_order (REQ-006).
- REQ-020 In ISSUE with hold=0, alu_stall SHALL be 0, the block SHALL capture alu_result into slice alu_part of the result register, and the step SHALL advance; in every other state or cycle alu_stall SHALL be 1.
- REQ-021 In ISSUE with hold=1, the step, alu_part, operand slices and result register SHALL hold unchanged.
- REQ-022 After the step-3 capture the FSM SHALL enter DONE; with no hold, wb_valid rises exactly 5 cycles after the accept edge.
- REQ-023 In DONE, wb_valid SHALL be 1 and wb_value stable until the wb_ready edge, after which the FSM returns to IDLE. The minimum spacing between accepts is 6 cycles.
- REQ-024 All 16 result bits SHALL be captured for every part, including descending-order parts whose slice is zero (SLT upper parts) and 32-bit parts 2/3 (sign extension); no masking is applied.
- REQ-025 flush=1 in ISSUE or DONE SHALL force IDLE on the next edge with wb_valid=0 and no writeback. flush=1 in IDLE SHALL block acceptance. flush overrides hold and wb_ready.
- REQ-026 When hold and flush are both 1, flush SHALL win; when flush and wb_ready are both 1 in DONE, the result SHALL be discarded.
- REQ-027 alu_rs1/alu_rs2 SHALL be slices of the registered operands only, and SHALL never be taken from live in_rs1/in_rs2 after acceptance.

Reset
- REQ-028 While reset=0, the block SHALL be in IDLE with step=0, the result register=0, the operand registers=0, wb_valid=0, in_ready=0, alu_stall=1 and alu_part=0.
- REQ-029 Reset asserted mid-ISSUE or in DONE SHALL abort immediately and asynchronously, with no writeback. After reset deasserts, in_ready SHALL be 1 on the first cycle.

Verification
- REQ-030 Ascending: in_order=00, rs1=0x0004_0003_0002_0001, ALU model returns rs1 slice -> alu_part sequence 0,1,2,3, alu_stall low for 4 cycles, wb_value=0x0004_0003_0002_0001, and wb_valid at accept+5.
- REQ-031 Descending: in_order=01, model returns 0x0000 for parts 3,2,1 and 0x0001 for part 0 -> alu_part sequence 3,2,1,0 and wb_value=0x0000_0000_0000_0001.
- REQ-032 32-bit shift: in_order=11 -> alu_part sequence 1,0,3,2, and each captured slice lands in its own position: model returns 0xAAAA(p1), 0xBBBB(p0), 0xFFFF(p3), 0xFFFF(p2) -> wb_value=0xFFFF_FFFF_AAAA_BBBB.
- REQ-033 Hold: hold=1 for 3 cycles during step 2 -> alu_part stays constant, alu_stall=1, and wb_valid is delayed to accept+8 with an unchanged wb_value.
- REQ-034 Backpressure/flush: wb_ready=0 for 4 cycles -> wb_valid and wb_value stable and in_ready=0; a separate run with flush pulsed at step 1 -> IDLE on the next cycle, no wb_valid, and in_ready=1.
- REQ-035 Reset mid-operation: reset=0 at step 2 -> outputs immediately take the REQ-028 values; a following ascending run produces the correct result.
